// File: rtl/mem_cmd_sequencer.sv
// Turns single core load/store requests into set-address + read/write command
// words for the bus master, caching the bus address and timing out stalled responses.
module mem_cmd_sequencer #(
  parameter int DW       = 32,
  parameter bit AUTO_INC = 1'b1,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [DW-3:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          cmd_stb,
  output logic [DW+1:0] cmd_word,
  input  logic          cmd_busy,
  input  logic          rsp_stb,
  input  logic [DW+1:0] rsp_word
);

  localparam int AW = DW - 2;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CMD, S_WAIT} state_t;

  state_t        r_state, w_state;
  logic          r_we, w_we;
  logic [AW-1:0] r_addr, w_addr;
  logic [DW-1:0] r_wdata, w_wdata;
  logic          r_cache_valid, w_cache_valid;
  logic [AW-1:0] r_cache_addr, w_cache_addr;
  logic [15:0]   r_tcnt, w_tcnt;
  logic          r_cmd_stb, w_cmd_stb;
  logic [DW+1:0] r_cmd_word, w_cmd_word;
  logic          r_resp_valid, w_resp_valid;
  logic [DW-1:0] r_resp_rdata, w_resp_rdata;
  logic          r_resp_err, w_resp_err;

  logic          w_cmd_acc;
  logic          w_hit;
  logic          w_rsp_ok;
  logic          w_finish;
  logic          w_timeout;
  logic [DW+1:0] w_rw_req;
  logic [DW+1:0] w_rw_cap;
  logic [DW+1:0] w_set_addr;

  assign w_cmd_acc  = r_cmd_stb && !cmd_busy;
  assign w_hit      = r_cache_valid && (req_addr == r_cache_addr);
  assign w_rsp_ok   = (rsp_word[DW+1:DW] == 2'b00);
  assign w_rw_req   = req_we ? {2'b01, req_wdata} : {2'b00, {DW{1'b0}}};
  assign w_rw_cap   = r_we   ? {2'b01, r_wdata}   : {2'b00, {DW{1'b0}}};
  assign w_set_addr = {2'b10, 1'b0, AUTO_INC, req_addr};

  always_comb begin
    w_state       = r_state;
    w_we          = r_we;
    w_addr        = r_addr;
    w_wdata       = r_wdata;
    w_cache_valid = r_cache_valid;
    w_cache_addr  = r_cache_addr;
    w_tcnt        = r_tcnt;
    w_cmd_stb     = r_cmd_stb;
    w_cmd_word    = r_cmd_word;
    w_resp_valid  = 1'b0;
    w_resp_rdata  = '0;
    w_resp_err    = 1'b0;
    w_finish      = 1'b0;
    w_timeout     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_we      = req_we;
          w_addr    = req_addr;
          w_wdata   = req_wdata;
          w_cmd_stb = 1'b1;
          if (w_hit) begin
            w_state    = S_CMD;
            w_cmd_word = w_rw_req;
          end else begin
            w_state    = S_ADDR;
            w_cmd_word = w_set_addr;
          end
        end
      end
      S_ADDR: begin
        if (w_cmd_acc) begin
          w_state    = S_CMD;
          w_cmd_word = w_rw_cap;
        end
      end
      S_CMD: begin
        if (w_cmd_acc) begin
          w_cmd_stb     = 1'b0;
          w_tcnt        = '0;
          w_cache_valid = 1'b1;
          w_cache_addr  = AUTO_INC ? r_addr + AW'(1) : r_addr;
          // A response arriving with the read/write acceptance completes the request.
          if (rsp_stb) w_finish = 1'b1;
          else         w_state  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_stb) begin
          w_finish = 1'b1;
        end else begin
          w_tcnt = r_tcnt + 16'd1;
          if (w_tcnt == 16'(TIMEOUT)) w_timeout = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (w_finish) begin
      w_state      = S_IDLE;
      w_resp_valid = 1'b1;
      w_resp_err   = !w_rsp_ok;
      w_resp_rdata = (w_rsp_ok && !r_we) ? rsp_word[DW-1:0] : '0;
      if (!w_rsp_ok) w_cache_valid = 1'b0;
    end

    if (w_timeout) begin
      w_state       = S_IDLE;
      w_resp_valid  = 1'b1;
      w_resp_err    = 1'b1;
      w_cache_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cache_valid <= 1'b0;
      r_cache_addr  <= '0;
      r_tcnt        <= '0;
      r_cmd_stb     <= 1'b0;
      r_cmd_word    <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_we          <= w_we;
      r_addr        <= w_addr;
      r_wdata       <= w_wdata;
      r_cache_valid <= w_cache_valid;
      r_cache_addr  <= w_cache_addr;
      r_tcnt        <= w_tcnt;
      r_cmd_stb     <= w_cmd_stb;
      r_cmd_word    <= w_cmd_word;
      r_resp_valid  <= w_resp_valid;
      r_resp_rdata  <= w_resp_rdata;
      r_resp_err    <= w_resp_err;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign cmd_stb    = r_cmd_stb;
  assign cmd_word   = r_cmd_word;

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Bench for mem_cmd_sequencer: acts as core and bus master, checking every cycle
// against a transaction-level model of the expected command list, latency and response.
module tb_mem_cmd_sequencer;

  localparam int DW = 32;
  localparam int AW = DW - 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          cmd_stb;
  logic [DW+1:0] cmd_word;
  logic          cmd_busy;
  logic          rsp_stb;
  logic [DW+1:0] rsp_word;

  int errors = 0;
  int checks = 0;

  // Model of the bus-address cache as seen from outside.
  bit            m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;

  mem_cmd_sequencer #(.DW(DW), .AUTO_INC(1'b1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .cmd_stb(cmd_stb), .cmd_word(cmd_word), .cmd_busy(cmd_busy),
    .rsp_stb(rsp_stb), .rsp_word(rsp_word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_valid = 1'b0;
    cmd_busy  = 1'b0;
    rsp_stb   = 1'b0;
    rsp_word  = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rvalid"}, resp_valid, 0);
    chk({tag, "_rdata"}, resp_rdata, 0);
    chk({tag, "_rerr"}, resp_err, 0);
    chk({tag, "_cstb"}, cmd_stb, 0);
    chk({tag, "_cword"}, cmd_word, 0);
  endtask

  // d: cycles from read/write acceptance to rsp_stb (0 = same cycle), -1 = never.
  task automatic run_req(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int b0, input int b1, input int d,
                         input logic [1:0] st, input logic [DW-1:0] rd);
    logic [DW+1:0] exp_cmd [2];
    logic [DW+1:0] rw;
    int busyl [2];
    int n, k, waitc, exp_lat, busy_total;
    bit miss, due, tmo, done;

    miss = !m_valid || (addr != m_addr);
    rw   = we ? {2'b01, wd} : {2'b00, 32'h0};
    if (miss) begin
      exp_cmd[0] = {2'b10, 1'b0, 1'b1, addr};
      exp_cmd[1] = rw;
      n = 2;
    end else begin
      exp_cmd[0] = rw;
      exp_cmd[1] = '0;
      n = 1;
    end
    busyl[0]   = b0;
    busyl[1]   = b1;
    busy_total = b0 + ((n == 2) ? b1 : 0);
    exp_lat    = n + busy_total + ((d < 0) ? TO : d) + 1;

    @(negedge clk);
    clear_inputs();
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;

    k = 0; waitc = 0; due = 0; tmo = 0; done = 0;
    for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
      @(negedge clk);
      clear_inputs();
      req_wdata = $urandom;
      if (due) begin
        chk("resp_valid", resp_valid, 1);
        chk("resp_err", resp_err, (tmo || st != 2'b00) ? 1 : 0);
        chk("resp_rdata", resp_rdata, (!tmo && st == 2'b00 && !we) ? rd : 0);
        chk("ready_at_resp", req_ready, 1);
        chk("cmd_stb_at_resp", cmd_stb, 0);
        chk("latency", cyc, exp_lat);
        if (tmo || st != 2'b00) m_valid = 1'b0;
        else begin
          m_valid = 1'b1;
          m_addr  = addr + AW'(1);
        end
        done = 1;
      end else begin
        chk("resp_quiet", resp_valid, 0);
        chk("cmd_stb", cmd_stb, (k < n) ? 1 : 0);
        if (k < n) begin
          chk(miss && k == 0 ? "cmd_setaddr" : "cmd_rw", cmd_word, exp_cmd[k]);
          if (busyl[k] > 0) begin
            cmd_busy = 1'b1;
            busyl[k]--;
          end else begin
            if (k == n - 1 && d == 0) begin
              rsp_stb  = 1'b1;
              rsp_word = {st, rd};
              due      = 1;
            end
            k++;
          end
        end else if (d > 0 && waitc == d - 1) begin
          rsp_stb  = 1'b1;
          rsp_word = {st, rd};
          due      = 1;
        end else begin
          waitc++;
          if (waitc == TO) begin
            due = 1;
            tmo = 1;
          end
        end
      end
    end
    if (!done) chk("resp_bound", 0, 1);
  endtask

  initial begin
    reset     = 1'b1;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("reset");

    // Read miss, then sequential hit, then a new address.
    run_req(1'b0, 30'h10, 32'h0, 0, 0, 1, 2'b00, 32'hDEADBEEF);
    run_req(1'b1, 30'h11, 32'h12345678, 0, 0, 1, 2'b00, 32'h0);
    run_req(1'b0, 30'h20, 32'h0, 0, 0, 0, 2'b00, 32'hCAFEF00D);

    // Backpressure on both commands.
    run_req(1'b0, 30'h40, 32'h0, 3, 2, 2, 2'b00, 32'hA5A5_0001);

    // Timeout, late response ignored, then cache must have been invalidated.
    run_req(1'b0, 30'h50, 32'h0, 0, 0, -1, 2'b00, 32'h0);
    @(negedge clk);
    clear_inputs();
    rsp_stb  = 1'b1;
    rsp_word = {2'b00, 32'hFFFF_FFFF};
    @(negedge clk);
    clear_inputs();
    chk("late_rsp_ignored", resp_valid, 0);
    chk("late_rsp_ready", req_ready, 1);
    run_req(1'b0, 30'h51, 32'h0, 0, 0, 1, 2'b00, 32'h1111_2222);
    // Response in the same cycle the counter would expire still wins.
    run_req(1'b0, 30'h52, 32'h0, 0, 0, TO, 2'b00, 32'h3333_4444);

    // Error response invalidates; wrap from all-ones to zero is a hit.
    run_req(1'b0, 30'h3FFFFFFF, 32'h0, 0, 0, 1, 2'b11, 32'h5555_6666);
    run_req(1'b0, 30'h3FFFFFFF, 32'h0, 0, 0, 1, 2'b00, 32'h7777_8888);
    run_req(1'b0, 30'h0, 32'h0, 0, 0, 1, 2'b00, 32'h9999_AAAA);

    // Reset while waiting for the response.
    @(negedge clk);
    clear_inputs();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 30'h77;
    repeat (3) begin
      @(negedge clk);
      clear_inputs();
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("midreset");
    rsp_stb  = 1'b1;
    rsp_word = {2'b00, 32'h1234_0000};
    @(negedge clk);
    clear_inputs();
    chk("post_reset_rsp", resp_valid, 0);
    @(negedge clk);
    chk("post_reset_rsp2", resp_valid, 0);
    m_valid = 1'b0;
    run_req(1'b0, 30'h78, 32'h0, 0, 0, 1, 2'b00, 32'hBEEF_0078);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      logic [1:0]    st;
      int            d;
      case ($urandom % 4)
        0, 1:    a = m_addr;
        2:       a = AW'($urandom);
        default: a = 30'h3FFFFFFF;
      endcase
      d  = $urandom_range(0, TO + 1);
      if (d == TO + 1) d = -1;
      st = (($urandom % 4) == 0) ? 2'($urandom) : 2'b00;
      run_req(1'($urandom), a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
              d, st, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
